// File: rtl/speed_meter.sv
// Receive-side decoder for the 16-clock speed pulse train: recovers the frame
// period and high time between rising edges, and flags a line without edges.
module speed_meter #(
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             speed_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] duty,
    output logic             valid,
    output logic             stalled,
    output logic [1:0]       dbg_state
);

    // valid is a one-cycle strobe with no ready: period/duty change only in
    // the cycle valid is high and hold their values until the next strobe.

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_d;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_duty;
    logic             r_valid;

    logic             w_s_q;
    logic             w_rise;
    logic             w_at_limit;
    logic             w_report;
    logic             w_stall_evt;

    assign w_s_q      = r_sync2;
    assign w_rise     = r_sync2 & ~r_prev;
    assign w_at_limit = (r_per_cnt == LIMIT);

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= speed_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ST_WAIT: no reference edge yet; ST_RUN: armed; ST_STALL: line timed out.
    always_comb begin
        w_state_d   = r_state;
        w_report    = 1'b0;
        w_stall_evt = 1'b0;
        if (w_rise) begin
            w_state_d = ST_RUN;
            w_report  = (r_state == ST_RUN);
        end else if (w_at_limit) begin
            w_state_d   = ST_STALL;
            w_stall_evt = (r_state != ST_STALL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else if (w_rise) begin
            r_per_cnt <= ONE;
            r_hi_cnt  <= ONE;
        end else if (!w_at_limit) begin
            r_per_cnt <= r_per_cnt + ONE;
            if (w_s_q && (r_hi_cnt != ALL_ONES)) begin
                r_hi_cnt <= r_hi_cnt + ONE;
            end
        end
    end

    // A stall reports once, with duty showing the level the line is stuck at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period <= '0;
            r_duty   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_report) begin
                r_period <= r_per_cnt;
                r_duty   <= r_hi_cnt;
                r_valid  <= 1'b1;
            end else if (w_stall_evt) begin
                r_period <= '0;
                r_duty   <= w_s_q ? ALL_ONES : '0;
                r_valid  <= 1'b1;
            end
        end
    end

    assign period    = r_period;
    assign duty      = r_duty;
    assign valid     = r_valid;
    assign stalled   = (r_state == ST_STALL);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_speed_meter.sv
// Directed bench for speed_meter: a frame generator drives the line, expected
// {period,duty} reports are queued and a monitor checks every valid strobe.
module tb_speed_meter;

  localparam int CNT_W = 6;
  localparam int TIMEOUT = 48;
  localparam int W = 2 * CNT_W;

  logic clk;
  logic rst;
  logic speed_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] duty;
  logic valid;
  logic stalled;
  logic [1:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int n_tests;
  int n_fail;

  speed_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .speed_in(speed_in),
    .period(period),
    .duty(duty),
    .valid(valid),
    .stalled(stalled),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_duty"}, int'(duty), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_stalled"}, int'(stalled), 0);
  endtask

  task automatic push_exp(input int p, input int d);
    logic [W-1:0] e;
    e = {CNT_W'(p), CNT_W'(d)};
    exp_q.push_back(e);
  endtask

  // driver: n frames of the generator waveform, high from position 16-sel
  task automatic run_frames(input int sel, input int n);
    for (int f = 0; f < n; f++) begin
      for (int pos = 0; pos < 16; pos++) begin
        @(negedge clk);
        speed_in = (pos >= 16 - sel);
      end
    end
  endtask

  task automatic hold_line(input logic lvl, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      speed_in = lvl;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got period=%0d duty=%0d with nothing expected", period, duty);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        n_tests++;
        if ({period, duty} !== e) begin
          n_fail++;
          $display("FAIL report: got period=%0d duty=%0d expected period=%0d duty=%0d",
                   period, duty, e[W-1:CNT_W], e[CNT_W-1:0]);
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    speed_in = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // sel=5 steady: first rise only arms
    push_exp(16, 5);
    push_exp(16, 5);
    push_exp(16, 5);
    run_frames(5, 4);

    // sel 5 -> 12 at a frame boundary: one short mixed frame, then exact 12
    push_exp(9, 5);
    push_exp(16, 12);
    push_exp(16, 12);
    run_frames(12, 3);
    hold_line(1'b0, 6);
    check("drained_before_reset", exp_q.size(), 0);

    // asynchronous reset between clock edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    push_exp(16, 12);
    push_exp(16, 12);
    run_frames(12, 3);

    // constant low from reset: one stall report, then silence
    hold_line(1'b0, 1);
    pulse_reset();
    push_exp(0, 0);
    hold_line(1'b0, 260);
    check("stall_low_stalled", int'(stalled), 1);

    // recover with sel=3: first rise clears stall without a report
    push_exp(16, 3);
    push_exp(16, 3);
    run_frames(3, 3);
    check("recover_stalled", int'(stalled), 0);

    // line stuck high after a frame
    push_exp(0, 63);
    hold_line(1'b1, 100);
    check("stall_high_stalled", int'(stalled), 1);
    check("stall_high_duty", int'(duty), 63);
    check("stall_high_period", int'(period), 0);

    hold_line(1'b0, 20);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/speed_meter.md
Name: speed_meter

Overview:
- Receive-side decoder for the 1-bit `speed` pulse train produced by the speed generator.
- That stream is a fixed 16-clock frame. The line rises at frame position 16-sel and falls at position 0, so it is high for `sel` clocks per frame; sel=0 gives a constant-low line.
- speed_meter recovers the frame period and the high time (duty) of each frame, and reports them with a one-cycle valid strobe.
- A stalled flag covers a line with no edges. Downstream display and control logic use these outputs to read back the commanded speed level.

Parameters:
- CNT_W, 6, width of the period and duty counters and outputs.
- TIMEOUT, 48, clocks without a rising edge before stall is declared (3 nominal frames); must be < 2^CNT_W.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- speed_in  input  1  pulse train from the speed generator (launched on negedge); asynchronous-safe.
- period  output  CNT_W  clocks between the last two rising edges.
- duty  output  CNT_W  high clocks within that frame.
- valid  output  1  one-cycle strobe when period/duty update.
- stalled  output  1  high while no rising edge has been seen for TIMEOUT clocks.

Behaviour:
- Reset (async, rst=1): period=0, duty=0, valid=0, stalled=0. Internally: synchronizer flops=0, s_prev=0, per_cnt=0, hi_cnt=0, armed=0. Reset mid-frame discards the partial frame; no valid for it.
- Input path: 2-flop synchronizer gives s_q, then s_prev=s_q delayed 1 clk. rise = s_q & ~s_prev. Latency from speed_in edge to rise is 2-3 clks, constant per edge, so period is unaffected.
- Per clock, in priority order:
  1. rise:
     - If armed: period<=per_cnt, duty<=hi_cnt, valid<=1.
     - Always: per_cnt<=1, hi_cnt<=1, armed<=1, stalled<=0.
  2. Else if per_cnt==TIMEOUT:
     - duty<= s_q ? all-ones : 0.
     - period<=0, valid<=1 only if stalled==0 (single strobe per stall), stalled<=1, armed<=0.
     - per_cnt holds at TIMEOUT.
  3. Else:
     - per_cnt<=per_cnt+1.
     - hi_cnt<=hi_cnt+s_q, saturating at all-ones.
- Counters never wrap; per_cnt is bounded by TIMEOUT, and hi_cnt saturates.
- First rise after reset or stall only arms; the first valid comes at the second rise.
- Nominal stream with sel=k (1..15): every 16 clks valid=1, period=16, duty=k.
- sel change mid-frame: the frame in progress may report a mixed duty; the next complete frame reports the new k exactly.
- A glitch that yields a rise within a frame produces a short frame; report it as measured, with no filtering.
- valid is high exactly one clk per event; period/duty hold between events.

Test Plan:
- rst pulse mid-run -> all outputs 0 immediately (async); next valid only after two further rises.
- sel=5 steady -> valid every 16 clks, period=16, duty=5; first valid at second rise after reset.
- sel 5→12 mid-frame -> at most one transitional report, then period=16, duty=12 on every subsequent valid.
- sel=0 (constant low) from reset -> after 48 clks stalled=1, valid once, duty=0, period=0; no further valid for 200 clks.
- Stall then sel=3 -> stalled clears on first rise, no valid on that rise; next rise gives valid, period=16, duty=3.
- speed_in forced high 100 clks after a frame -> stall at per_cnt=48 with duty=63, period=0, single valid.
